// File: rtl/fpu_pkg.sv
// fpu_pkg: operation encodings, FSM states, exponent bias, special results and flag positions for the FP unit
package fpu_pkg;
    localparam logic [1:0] FPU_ADD = 2'b00;
    localparam logic [1:0] FPU_MUL = 2'b01;
    localparam logic [1:0] FPU_SUB = 2'b10;
    localparam logic [1:0] FPU_RSV = 2'b11;
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_UNPACK = 3'd1;
    localparam state_t S_ALIGN  = 3'd2;
    localparam state_t S_MUL    = 3'd3;
    localparam state_t S_NORM   = 3'd4;
    localparam state_t S_PACK   = 3'd5;
    localparam state_t S_DONE   = 3'd6;
    localparam int FP_BIAS = 127;
    localparam logic [31:0] FP_NAN = 32'h7FC0_0000;
    localparam logic [31:0] FP_INF = 32'h7F80_0000;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
endpackage

// File: rtl/fpu_unpack.sv
// fpu_unpack: splits an IEEE-754 single into sign, exponent and mantissa, flagging zero and inf/NaN exponents
module fpu_unpack #(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic [MANT_W+EXP_W:0] x,
    output logic                  sign,
    output logic [EXP_W-1:0]      ex,
    output logic [MANT_W:0]       mant,
    output logic                  zero,
    output logic                  special
);
    assign sign    = x[MANT_W+EXP_W];
    assign ex      = x[MANT_W+EXP_W-1:MANT_W];
    assign zero    = ex == '0;
    assign special = &ex;
    assign mant    = {!zero, x[MANT_W-1:0]};
endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: multicycle single-precision FADD/FSUB/FMUL unit that stalls the datapath while an operation runs
module fpu_seq
    import fpu_pkg::*;
#(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8,
    parameter int BIAS   = FP_BIAS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  FPUControl,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic [31:0] FPUResult,
    output logic [3:0]  FPUFlags,
    output logic        busy,
    output logic        done,
    output logic        stall
);
    localparam int MW = MANT_W + 1;
    localparam int GW = MANT_W + 3;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EONE = XW'(1);
    localparam logic [3:0] V_ONLY = 4'(1 << FLAG_V);
    state_t state;
    logic [31:0] a_r, b_r, pre_res, res_nx;
    logic [1:0] op_r;
    logic [3:0] pre_flg, flg_nx;
    logic sa, sb, sbe, za, zb, xa, xb;
    logic [EXP_W-1:0] ea, eb, el, es, diff;
    logic [MANT_W:0] ma, mb, mae, mbe, ml, ms, kept;
    logic a_big, sl, ss, far, lost;
    logic [MW+GW-1:0] ext;
    logic [MW:0] sum, mant_r;
    logic sign_r, inex_r, pre_r;
    logic signed [XW-1:0] exp_r;
    logic [2*MW-1:0] prod_r, prod_nx;
    logic [4:0] cnt_r;
    fpu_unpack #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_a (.x(a_r), .sign(sa), .ex(ea), .mant(ma), .zero(za), .special(xa));
    fpu_unpack #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_b (.x(b_r), .sign(sb), .ex(eb), .mant(mb), .zero(zb), .special(xb));
    assign mae = za ? '0 : ma;
    assign mbe = zb ? '0 : mb;
    assign sbe = sb ^ (op_r == FPU_SUB);
    assign busy  = state != S_IDLE && state != S_DONE;
    assign done  = state == S_DONE;
    assign stall = busy | (start & (state == S_IDLE));
    // Larger magnitude goes first; bits shifted out of the smaller operand only feed the inexact flag
    always_comb begin
        a_big = {ea, mae} >= {eb, mbe};
        sl    = a_big ? sa : sbe;
        ss    = a_big ? sbe : sa;
        el    = a_big ? ea : eb;
        es    = a_big ? eb : ea;
        ml    = a_big ? mae : mbe;
        ms    = a_big ? mbe : mae;
        diff  = el - es;
        far   = diff >= EXP_W'(GW);
        ext   = {ms, {GW{1'b0}}} >> diff;
        kept  = far ? '0 : ext[MW+GW-1:GW];
        lost  = far ? |ms : |ext[GW-1:0];
        sum   = sl == ss ? {1'b0, ml} + {1'b0, kept} : {1'b0, ml} - {1'b0, kept};
    end
    assign prod_nx = prod_r + (mbe[cnt_r] ? ({{MW{1'b0}}, mae} << cnt_r) : '0);
    always_comb begin
        res_nx = {sign_r, exp_r[EXP_W-1:0], mant_r[MANT_W-1:0]};
        flg_nx = '0;
        flg_nx[FLAG_N] = sign_r;
        flg_nx[FLAG_C] = inex_r;
        if (pre_r) begin
            res_nx = pre_res;
            flg_nx = pre_flg;
        end else if (mant_r == '0) begin
            res_nx = '0;
            flg_nx[FLAG_Z] = 1'b1;
        end else if (exp_r >= EMAX) begin
            res_nx = FP_INF | {sign_r, 31'b0};
            flg_nx[FLAG_V] = 1'b1;
        end else if (exp_r < EONE) begin
            res_nx = {sign_r, 31'b0};
            flg_nx[FLAG_Z] = 1'b1;
            flg_nx[FLAG_C] = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            FPUResult <= '0;
            FPUFlags  <= '0;
            a_r       <= '0;
            b_r       <= '0;
            op_r      <= FPU_ADD;
            sign_r    <= 1'b0;
            inex_r    <= 1'b0;
            pre_r     <= 1'b0;
            pre_res   <= '0;
            pre_flg   <= '0;
            exp_r     <= '0;
            mant_r    <= '0;
            prod_r    <= '0;
            cnt_r     <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    a_r   <= SrcA;
                    b_r   <= SrcB;
                    op_r  <= FPUControl;
                    state <= S_UNPACK;
                end
                S_UNPACK: begin
                    inex_r <= 1'b0;
                    pre_r  <= 1'b0;
                    prod_r <= '0;
                    cnt_r  <= '0;
                    if (xa | xb) begin
                        pre_r   <= 1'b1;
                        pre_res <= FP_NAN;
                        pre_flg <= V_ONLY;
                        state   <= S_PACK;
                    end else if (op_r == FPU_RSV) begin
                        pre_r   <= 1'b1;
                        pre_res <= '0;
                        pre_flg <= '0;
                        state   <= S_PACK;
                    end else if (op_r == FPU_MUL) begin
                        sign_r <= sa ^ sb;
                        exp_r  <= XW'(ea) + XW'(eb) - XW'(BIAS);
                        state  <= S_MUL;
                    end else begin
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    sign_r <= sl;
                    exp_r  <= XW'(el);
                    mant_r <= sum;
                    inex_r <= lost;
                    state  <= S_NORM;
                end
                S_MUL: begin
                    prod_r <= prod_nx;
                    cnt_r  <= cnt_r + 1'b1;
                    if (cnt_r == 5'(MANT_W)) begin
                        mant_r <= prod_nx[2*MW-1:MANT_W];
                        inex_r <= |prod_nx[MANT_W-1:0];
                        state  <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (mant_r == '0) begin
                        sign_r <= 1'b0;
                        state  <= S_PACK;
                    end else if (mant_r[MW]) begin
                        mant_r <= mant_r >> 1;
                        exp_r  <= exp_r + 1'b1;
                        inex_r <= inex_r | mant_r[0];
                        state  <= S_PACK;
                    end else if (mant_r[MANT_W]) begin
                        state <= S_PACK;
                    end else begin
                        mant_r <= mant_r << 1;
                        exp_r  <= exp_r - 1'b1;
                    end
                end
                S_PACK: begin
                    FPUResult <= res_nx;
                    FPUFlags  <= flg_nx;
                    state     <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
